// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider and its ratio monitor.
// State encodings and default sizing constants.
package clk_div_pkg;

    localparam int DEF_MAX_N       = 1024;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

endpackage

// File: rtl/edge_sync_detect.sv
// Multi-flop synchronizer for an asynchronous level, plus
// single-cycle rise/fall pulses on the synchronized signal.
module edge_sync_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              s_d_q;
    logic              s;

    assign s = sync_q[STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            s_d_q  <= s;
        end
    end

    assign rise_o = s & ~s_d_q;
    assign fall_o = ~s & s_d_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of a divided clock in reference
// cycles, checks duty cycle and reports ratio lock / timeout.
module clk_ratio_monitor
    import clk_div_pkg::*;
#(
    parameter int MAX_N       = DEF_MAX_N,
    parameter int CNT_W       = $clog2(MAX_N + 1),
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_COUNT  = 4,
    parameter int DUTY_TOL    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             duty_ok,
    output logic             locked,
    output logic             timeout
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_N);
    localparam logic [MW-1:0]    LOCK_C = MW'(LOCK_COUNT);
    localparam logic [CNT_W:0]   TOL_C  = (CNT_W + 1)'(DUTY_TOL);

    logic             rise;
    logic             fall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_stage_q;
    logic             fall_seen_q;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             mv_q, mv_d;
    logic             duty_q, duty_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [MW-1:0]    match_q, match_d;

    logic             upd;
    logic             expire;
    logic [CNT_W-1:0] hi_val;
    logic [MW-1:0]    match_nx;
    logic [CNT_W:0]   twice_hi;
    logic [CNT_W:0]   per_x;
    logic [CNT_W:0]   diff;
    logic             duty_calc;

    edge_sync_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (clk_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    // A rise in the saturating cycle counts as a measurement, not a timeout.
    assign upd    = rise && (state_q != IDLE);
    assign expire = !rise && (state_q != IDLE) && (cnt_q == MAX_C);

    // Without a fall since the last rise, the line was high all period.
    assign hi_val   = fall_seen_q ? hi_stage_q : cnt_q;
    assign twice_hi = {hi_val, 1'b0};
    assign per_x    = {1'b0, cnt_q};
    assign diff     = (twice_hi >= per_x) ? (twice_hi - per_x)
                                          : (per_x - twice_hi);
    assign duty_calc = fall_seen_q && (diff <= TOL_C);

    always_comb begin
        match_nx = MW'(1);
        if (state_q != MEASURE && cnt_q == period_q) begin
            match_nx = (match_q >= LOCK_C) ? LOCK_C : match_q + MW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = MEASURE;
            end
            MEASURE, TRACK, LOCKED: begin
                if (expire) begin
                    state_d = IDLE;
                end else if (rise) begin
                    state_d = (match_nx >= LOCK_C) ? LOCKED : TRACK;
                end
            end
        endcase
    end

    always_comb begin
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        locked_d  = locked_q;
        match_d   = match_q;
        mv_d      = 1'b0;
        timeout_d = 1'b0;
        if (expire) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
        end else if (upd) begin
            period_d = cnt_q;
            high_d   = hi_val;
            duty_d   = duty_calc;
            mv_d     = 1'b1;
            match_d  = match_nx;
            locked_d = (state_d == LOCKED);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            hi_stage_q  <= '0;
            fall_seen_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            mv_q        <= 1'b0;
            duty_q      <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            match_q     <= '0;
        end else begin
            if (rise) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != MAX_C) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (fall) hi_stage_q <= cnt_q;
            if (rise)      fall_seen_q <= 1'b0;
            else if (fall) fall_seen_q <= 1'b1;
            period_q  <= period_d;
            high_q    <= high_d;
            mv_q      <= mv_d;
            duty_q    <= duty_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            match_q   <= match_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign duty_ok    = duty_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/clk_ratio_monitor.md
Name: clk_ratio_monitor

Overview:
- Receive-side companion to the team's clock frequency divider.
- Samples a divided clock (clk_in) in the reference clock domain and measures its period and high time in reference-clock cycles.
- Flags duty-cycle compliance and asserts lock once the ratio is stable.
- Used as on-chip self-check of divider outputs and as a ratio detector for downstream clock-management logic.

Parameters:
- MAX_N, 1024, largest measurable period in clk cycles; reaching it without a rising edge is a timeout.
- CNT_W, $clog2(MAX_N+1), width of the counter and measurement outputs.
- SYNC_STAGES, 2, synchronizer flops on clk_in (minimum 2).
- LOCK_COUNT, 4, consecutive equal periods required to assert locked.
- DUTY_TOL, 1, allowed |2*high_time - period|, in cycles.

Ports:
- clk  input  1  reference clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- clk_in  input  1  divided clock under measurement; treated as asynchronous.
- period  output  CNT_W  last measured period, rise-to-rise, in clk cycles.
- high_time  output  CNT_W  high time of the same period, in clk cycles.
- meas_valid  output  1  one-cycle pulse when period/high_time update.
- duty_ok  output  1  last measurement within DUTY_TOL.
- locked  output  1  ratio stable.
- timeout  output  1  one-cycle pulse when no rising edge is seen for MAX_N cycles.

Behaviour:
- Reset (rst=0, async): all outputs 0, cnt 0, match count 0, synchronizer cleared, state IDLE. Takes effect mid-operation with no partial update.
- Edge detect: synchronized signal s is registered once more. rise = s & ~s_d, fall = ~s & s_d. Latency from a clk_in edge to rise/fall is SYNC_STAGES+1 cycles.
- Counter: on rise, cnt <= 1. Otherwise cnt <= cnt+1, saturating at MAX_N.
- On fall: hi_stage <= cnt.
- States:
  - IDLE: wait for first rise. On rise -> MEASURE. No output update.
  - MEASURE/TRACK: on each rise, period <= cnt and high_time <= hi_stage, and meas_valid pulses the next cycle.
  - Match tracking: if the new period equals the previous period, match count increments (saturating at LOCK_COUNT); otherwise match count <= 1. The first measured period sets match count to 1.
  - When match count reaches LOCK_COUNT -> LOCKED, and locked asserts in the same cycle as that meas_valid.
  - LOCKED: outputs keep updating each period. A period mismatch deasserts locked in the same cycle as its meas_valid, sets match count to 1, and returns to TRACK.
- duty_ok is registered with meas_valid: 1 iff |2*high_time - period| <= DUTY_TOL. It holds its value between updates.
- Timeout: cnt reaching MAX_N in any non-IDLE state pulses timeout for 1 cycle, clears locked and match count, and returns to IDLE. period, high_time and duty_ok hold their values. Timeout is not re-pulsed until a rise occurs.
- No fall between two rises (glitch or stuck-high): high_time <= period and duty_ok = 0.
- Simultaneous rise and saturation in the same cycle: rise wins and no timeout is raised.
- Odd ratios: posedge sampling quantizes high_time to floor or ceil of N/2. DUTY_TOL=1 accepts both.

Decomposition:
- Shared package/header clk_div_pkg:
  - state encodings IDLE/MEASURE/TRACK/LOCKED.
  - default MAX_N and SYNC_STAGES constants, shared with the divider.
- One sub-module, edge_sync_detect: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Reusable elsewhere in the codebase.

Test Plan:
- Divide-by-4 50% source: meas_valid every 4 cycles, period=4, high_time=2, duty_ok=1. locked rises on the meas_valid of the 5th rising edge (4th measured period).
- Divide-by-5 50% source: period=5, high_time in {2,3}, duty_ok=1, locked after 4 periods.
- Divide-by-6 with high=1 cycle: period=6, high_time=1, duty_ok=0, locked still asserts (duty does not gate lock).
- Locked at N=4, switch source to N=6: locked drops on the first period=6 meas_valid and re-asserts on the 4th consecutive period=6.
- MAX_N=16, clk_in held low after lock: timeout pulses exactly once, 16 cycles after the last cnt<=1 load. locked=0, period holds 4. Resuming the N=4 source relocks after 5 rises.
- rst low mid-LOCKED, asynchronously between clk edges: all outputs 0 immediately. After release, a full relock sequence completes with the same values as scenario 1.
